dsp_bus_bridge: RTL and testbench

- Parametrised successor to the 16-bit DSP external-bus bidirectional interface.
- Decodes DSP re/we/cs strobes and drives N_CH sub-module read channels onto a tri-state data bus with fixed priority.
- Adds a configurable write-settle delay, single-cycle write/read strobes, latched write data and address, and a built-in status register that counts read collisions and unanswered reads.
- Sits between the FPGA top-level pins and the application sub-modules; one instance per DSP bus.

---
 rtl/dsp_bus_bridge_if.sv | 16 +
 rtl/dsp_bus_bridge.sv | 155 +++++++++++++++
 tb/tb_dsp_bus_bridge.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_bus_bridge_if.sv
// DSP external-bus strobe/address group.
//   re, we, cs : active-low read enable, write enable, chip select
//   ab         : address bus
// The DSP side drives these signals (master). The bridge only samples them (slave).
// The bidirectional data bus stays a plain inout pin on the bridge.
interface dsp_bus_bridge_if #(
  parameter int unsigned AW = 8
);
  logic          re;
  logic          we;
  logic          cs;
  logic [AW-1:0] ab;

  modport master (output re, we, cs, ab);
  modport slave  (input  re, we, cs, ab);
endinterface

// File: rtl/dsp_bus_bridge.sv
// dsp_bus_bridge: DSP external-bus bidirectional interface.
//
// Decodes the DSP re/we/cs strobes. During reads it drives one of N_CH
// sub-module channels, a status word, or an idle pattern onto the tri-state
// data bus. During writes it latches data and address behind a configurable
// write-enable settle delay.
//
// Ports:
//   xclk            master clock (DSP external bus clock)
//   reset           asynchronous reset, active-low
//   db              bidirectional data bus, driven only while oe_reg is set
//   bus             re/we/cs/ab from the DSP (slave modport)
//   ch_rd_data      channel read data, channel k at [k*DW +: DW]
//   ch_rd_avail     channel k claims the current read (channel 0 has highest priority)
//   read_qualified  !re & !cs, combinational
//   write_qualified delayed we qualified by cs
//   wr_strobe       one-cycle pulse per write transaction
//   rd_strobe       one-cycle pulse per read transaction
//   wr_data/wr_addr data and address latched with wr_strobe
//   db_in           unregistered copy of db
//   hb_out          heartbeat square wave
//   stat_irq        high while the collision or miss count is nonzero
module dsp_bus_bridge #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 8,
  parameter int unsigned N_CH      = 3,
  parameter int unsigned WE_DLY    = 2,
  parameter int unsigned AB_OFFSET = 0,
  parameter int unsigned STAT_ADDR = 'hFF,
  parameter logic [3:0]  BUS_ID    = 4'd0,
  parameter logic [15:0] IDLE_PAT  = 16'h3333,
  parameter int unsigned HB_BIT    = 7
) (
  input  logic                 xclk,
  input  logic                 reset,
  inout  wire  [DW-1:0]        db,
  dsp_bus_bridge_if.slave      bus,
  input  logic [N_CH*DW-1:0]   ch_rd_data,
  input  logic [N_CH-1:0]      ch_rd_avail,
  output logic                 read_qualified,
  output logic                 write_qualified,
  output logic                 wr_strobe,
  output logic                 rd_strobe,
  output logic [DW-1:0]        wr_data,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        db_in,
  output logic                 hb_out,
  output logic                 stat_irq
);

  localparam logic [AW-1:0] STAT_DEC = AW'(AB_OFFSET + STAT_ADDR);

  logic [WE_DLY-1:0] we_del;
  logic              wq_d;
  logic              oe_reg;
  logic [3:0]        coll_cnt;
  logic [3:0]        miss_cnt;
  logic [8:0]        hb_cnt;
  logic [DW-1:0]     status_word;
  logic [DW-1:0]     drive_val;
  logic              stat_hit;
  logic              collision;
  logic              miss;
  logic              stat_clear;
  logic              wr_edge;

  assign stat_hit        = (bus.ab == STAT_DEC);
  assign read_qualified  = !bus.re && !bus.cs;
  assign write_qualified = !we_del[WE_DLY-1] && !bus.cs;
  assign wr_edge         = write_qualified && !wq_d;
  assign db_in           = db;
  assign db              = oe_reg ? drive_val : {DW{1'bz}};
  assign hb_out          = hb_cnt[HB_BIT];
  assign stat_irq        = (coll_cnt != 4'd0) || (miss_cnt != 4'd0);

  // Error events are judged during the rd_strobe cycle. The clear is judged
  // during the wr_strobe cycle from the latched address and data.
  assign collision  = rd_strobe && !stat_hit && ($countones(ch_rd_avail) > 1);
  assign miss       = rd_strobe && !stat_hit && (ch_rd_avail == '0);
  assign stat_clear = wr_strobe && (wr_addr == STAT_DEC) && wr_data[0];

  always_comb begin
    status_word        = '0;
    status_word[15:12] = BUS_ID;
    status_word[11:8]  = coll_cnt;
    status_word[7:4]   = miss_cnt;
  end

  // Scan from the highest channel down so that the lowest claiming channel
  // wins. The status address overrides every channel.
  always_comb begin
    drive_val = DW'(IDLE_PAT);
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ch_rd_avail[N_CH-1-k]) drive_val = ch_rd_data[(N_CH-1-k)*DW +: DW];
    end
    if (stat_hit) drive_val = status_word;
  end

  // we is shifted through we_del. When we is high the register is forced to
  // all ones, so the end of a write is seen with no delay.
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      we_del <= '1;
    end else if (bus.we) begin
      we_del <= '1;
    end else begin
      we_del <= WE_DLY'({we_del, 1'b0});
    end
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      wq_d      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= '0;
    end else begin
      wq_d      <= write_qualified;
      wr_strobe <= wr_edge;
      if (wr_edge) begin
        wr_data <= db;
        wr_addr <= bus.ab;
      end
    end
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      oe_reg    <= 1'b0;
      rd_strobe <= 1'b0;
    end else begin
      oe_reg    <= read_qualified;
      rd_strobe <= read_qualified && !oe_reg;
    end
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      coll_cnt <= '0;
      miss_cnt <= '0;
    end else if (stat_clear) begin
      coll_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (collision && coll_cnt != 4'hF) coll_cnt <= coll_cnt + 4'd1;
      if (miss && miss_cnt != 4'hF)      miss_cnt <= miss_cnt + 4'd1;
    end
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) hb_cnt <= '0;
    else        hb_cnt <= hb_cnt + 9'd1;
  end

endmodule

// File: tb/tb_dsp_bus_bridge.sv
// Scoreboard bench for dsp_bus_bridge.
// Stimulus tasks push expected read words and expected write {addr, data} pairs
// into queues. A transaction-level model computes these values and tracks the
// error counts. A negedge monitor pops and compares on every rd_strobe and
// wr_strobe.
module tb_dsp_bus_bridge;
  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 8;
  localparam int unsigned N_CH   = 3;
  localparam int unsigned WE_DLY = 2;

  logic                xclk = 1'b0;
  logic                reset;
  wire  [DW-1:0]       db;
  logic                tb_en;
  logic [DW-1:0]       tb_val;
  logic [N_CH*DW-1:0]  ch_rd_data;
  logic [N_CH-1:0]     ch_rd_avail;
  logic                read_qualified, write_qualified, wr_strobe, rd_strobe;
  logic [DW-1:0]       wr_data, db_in;
  logic [AW-1:0]       wr_addr;
  logic                hb_out, stat_irq;

  int n_total = 0;
  int n_pass  = 0;
  int m_coll  = 0;
  int m_miss  = 0;
  int rd_seen = 0;
  int hb_cyc  = 0;

  logic [15:0] rd_q[$];
  logic [23:0] wr_q[$];

  dsp_bus_bridge_if #(.AW(AW)) bus ();

  assign db = tb_en ? tb_val : {DW{1'bz}};

  dsp_bus_bridge #(
    .DW(DW), .AW(AW), .N_CH(N_CH), .WE_DLY(WE_DLY), .AB_OFFSET(0),
    .STAT_ADDR('hFF), .BUS_ID(4'd0), .IDLE_PAT(16'h3333), .HB_BIT(7)
  ) dut (
    .xclk(xclk), .reset(reset), .db(db), .bus(bus),
    .ch_rd_data(ch_rd_data), .ch_rd_avail(ch_rd_avail),
    .read_qualified(read_qualified), .write_qualified(write_qualified),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
    .wr_data(wr_data), .wr_addr(wr_addr), .db_in(db_in),
    .hb_out(hb_out), .stat_irq(stat_irq)
  );

  always #5 xclk = ~xclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level model of one read: the value the bus must carry and
  // the effect of the read on the error counts.
  function automatic logic [15:0] model_read(input logic [7:0] a, input logic [2:0] av,
                                             input logic [47:0] d);
    int n;
    if (a == 8'hFF) return {4'h0, m_coll[3:0], m_miss[3:0], 4'h0};
    n = int'(av[0]) + int'(av[1]) + int'(av[2]);
    if (n > 1 && m_coll < 15) m_coll++;
    if (n == 0 && m_miss < 15) m_miss++;
    if (av[0]) return d[15:0];
    if (av[1]) return d[31:16];
    if (av[2]) return d[47:32];
    return 16'h3333;
  endfunction

  // Heartbeat reference: the number of clock edges since reset was released.
  always @(posedge xclk or negedge reset) begin
    if (!reset) hb_cyc = 0;
    else        hb_cyc = hb_cyc + 1;
  end

  always @(negedge xclk) begin
    if (reset) begin
      if (hb_cyc % 37 == 5) check("heartbeat", 32'(hb_out), 32'((hb_cyc >> 7) & 1));
      if (rd_strobe) begin
        rd_seen++;
        if (rd_q.size() == 0) check("unexpected_rd_strobe", 32'd1, 32'd0);
        else check("read_data", 32'(db), 32'(rd_q.pop_front()));
      end
      if (wr_strobe) begin
        if (wr_q.size() == 0) check("unexpected_wr_strobe", 32'd1, 32'd0);
        else check("write_latch", {8'h0, wr_addr, wr_data}, {8'h0, wr_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge xclk);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [2:0] av, input logic [47:0] d,
                         input int hold);
    ch_rd_data  = d;
    ch_rd_avail = av;
    bus.ab      = a;
    bus.cs      = 1'b0;
    bus.re      = 1'b0;
    rd_q.push_back(model_read(a, av, d));
    idle(hold);
    bus.re = 1'b1;
    bus.cs = 1'b1;
    idle(2);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    tb_val = d;
    tb_en  = 1'b1;
    bus.ab = a;
    bus.cs = 1'b0;
    bus.we = 1'b0;
    wr_q.push_back({a, d});
    if (a == 8'hFF && d[0]) begin
      m_coll = 0;
      m_miss = 0;
    end
    idle(WE_DLY + 3);
    bus.we = 1'b1;
    bus.cs = 1'b1;
    tb_en  = 1'b0;
    idle(2);
  endtask

  task automatic check_irq(input string name);
    check(name, 32'(stat_irq), 32'((m_coll != 0) || (m_miss != 0)));
  endtask

  initial begin
    logic [7:0]  ra;
    logic [15:0] rd;
    logic [47:0] d48;
    int          rb;
    reset = 1'b0;
    tb_en = 1'b0;
    tb_val = '0;
    bus.re = 1'b1; bus.we = 1'b1; bus.cs = 1'b1; bus.ab = '0;
    ch_rd_data = '0; ch_rd_avail = '0;
    idle(3);
    check("reset_oe", 32'(dut.oe_reg), 32'd0);
    check("reset_we_del", 32'(dut.we_del), 32'h3);
    check("reset_strobes", {30'd0, wr_strobe, rd_strobe}, 32'd0);
    check("reset_irq_hb", {30'd0, stat_irq, hb_out}, 32'd0);
    reset = 1'b1;
    idle(2);

    // Write timing: write_qualified 2 edges after we falls, then wr_strobe 1 edge later.
    tb_val = 16'hA5C3; tb_en = 1'b1; bus.ab = 8'h10; bus.cs = 1'b0; bus.we = 1'b0;
    wr_q.push_back({8'h10, 16'hA5C3});
    @(negedge xclk); check("wq_after_1", 32'(write_qualified), 32'd0);
    @(negedge xclk); check("wq_after_2", {30'd0, write_qualified, wr_strobe}, 32'h2);
    @(negedge xclk); check("wr_strobe_3", 32'(wr_strobe), 32'd1);
    check("wr_latch_3", {8'h0, wr_addr, wr_data}, {8'h0, 8'h10, 16'hA5C3});
    @(negedge xclk); check("wr_strobe_4", 32'(wr_strobe), 32'd0);
    bus.we = 1'b1; bus.cs = 1'b1; tb_en = 1'b0;
    @(negedge xclk); check("wq_drop", 32'(write_qualified), 32'd0);
    idle(2);

    // Read priority and collision.
    do_read(8'h30, 3'b110, {16'h2222, 16'h1111, 16'hAAAA}, 3);
    check_irq("irq_after_collision");
    do_read(8'hFF, 3'b011, 48'h123456789ABC, 3);
    do_read(8'hFF, 3'b000, '0, 3);
    check_irq("irq_after_status_reads");

    // Clear through the status address.
    do_write(8'hFF, 16'h0001);
    do_read(8'hFF, 3'b111, 48'hFFFF_FFFF_FFFF, 3);
    check_irq("irq_after_clear");

    // Miss saturation.
    for (int i = 0; i < 17; i++) do_read(8'h40, 3'b000, 48'h5555_6666_7777, 3);
    do_read(8'hFF, 3'b000, '0, 3);
    check("miss_model_sat", 32'(m_miss), 32'd15);
    check_irq("irq_after_misses");

    // Chip select gating.
    rb = rd_seen;
    bus.re = 1'b0; bus.cs = 1'b1;
    idle(4);
    check("cs_gate_oe", 32'(dut.oe_reg), 32'd0);
    check("cs_gate_no_strobe", 32'(rd_seen), 32'(rb));
    bus.re = 1'b1;
    idle(2);

    // re and we both low: the write captures the value the bridge drives.
    ch_rd_data = {16'h0, 16'h0, 16'hBEEF}; ch_rd_avail = 3'b001;
    bus.ab = 8'h20; bus.cs = 1'b0; bus.re = 1'b0; bus.we = 1'b0;
    rd_q.push_back(model_read(8'h20, 3'b001, {16'h0, 16'h0, 16'hBEEF}));
    wr_q.push_back({8'h20, 16'hBEEF});
    idle(WE_DLY + 3);
    check("both_low_driven", {31'd0, dut.oe_reg}, 32'd1);
    bus.re = 1'b1; bus.we = 1'b1; bus.cs = 1'b1;
    idle(2);

    // cs rising in the middle of a read.
    ch_rd_avail = 3'b001; bus.ab = 8'h50; bus.cs = 1'b0; bus.re = 1'b0;
    rd_q.push_back(model_read(8'h50, 3'b001, ch_rd_data));
    idle(2);
    check("cs_mid_oe_on", 32'(dut.oe_reg), 32'd1);
    bus.cs = 1'b1;
    @(negedge xclk); check("cs_mid_oe_off", 32'(dut.oe_reg), 32'd0);
    bus.re = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        ra = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        d48 = {16'($urandom), 16'($urandom), 16'($urandom)};
        do_read(ra, 3'($urandom), d48, $urandom_range(2, 4));
      end else begin
        ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        rd = 16'($urandom);
        do_write(ra, rd);
      end
      check_irq("irq_random");
    end

    // Reset in the middle of a read.
    ch_rd_data = {16'h0, 16'h7777, 16'h0}; ch_rd_avail = 3'b010;
    bus.ab = 8'h60; bus.cs = 1'b0; bus.re = 1'b0;
    rd_q.push_back(model_read(8'h60, 3'b010, ch_rd_data));
    idle(2);
    check("pre_reset_oe", 32'(dut.oe_reg), 32'd1);
    reset = 1'b0;
    #1;
    check("reset_mid_oe", 32'(dut.oe_reg), 32'd0);
    check("reset_mid_we_del", 32'(dut.we_del), 32'h3);
    check("reset_mid_latches", {8'h0, wr_addr, wr_data}, 32'd0);
    check("reset_mid_flags", {27'd0, wr_strobe, rd_strobe, stat_irq, hb_out, write_qualified},
          32'd0);
    m_coll = 0; m_miss = 0;
    bus.re = 1'b1; bus.cs = 1'b1;
    idle(2);
    reset = 1'b1;
    idle(2);
    do_read(8'hFF, 3'b101, 48'h1, 3);
    check_irq("irq_final");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && (rd_q.size() != 0 || wr_q.size() != 0); i++) idle(1);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
